// File: rtl/tdc_hit_classifier.sv
// tdc_hit_classifier: per-channel TDC leading-edge finder, particle classifier and hit FIFO; define TDC_HITCNT_EN for per-class hit counters
module tdc_hit_classifier #(
  parameter logic [4:0] CH = 5'd0,
  parameter int NTAP = 32,
  parameter int NCLASS = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int CT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NTAP+3:0]   tap_snap,
  input  logic              snap_vld,
  output logic [NCLASS-1:0] class_hit,
  output logic              hit_rdy,
  output logic [31:0]       DataOut,
  input  logic [31:0]       DataIn,
  input  logic [7:0]        Address,
  input  logic              Read,
  input  logic              Write
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [8:0] CFG_M = 9'h100 | 9'((1 << NCLASS) - 1);
  localparam logic [63:0] WIN1_D = 64'h0000_F000;
  localparam logic [63:0] WIN2_D = 64'h0F00_0000;
  logic [CT_W-1:0] r_coarse, r_stamp;
  logic [NTAP-1:0] w_edge, r_edge;
  logic [NTAP-1:0] r_win [4];
  logic [8:0] r_cfg;
  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [6:0] r_cnt;
  logic r_ovf;
  logic [NCLASS-1:0] r_class_hit, w_cls;
  logic [31:0] r_dout, w_rdata, w_rec, w_hitcnt;
  logic [5:0] w_fine;
  logic [1:0] w_widx;
  logic [63:0] w_wx;
  logic [2:0] w_off;
  logic w_multi, w_sel, w_rd, w_wr, w_clr, w_full, w_empty, w_push, w_pop, w_unused;
  assign w_edge = {NTAP{snap_vld}} & tap_snap[NTAP:1] & tap_snap[NTAP+1:2] & tap_snap[NTAP+2:3] & ~tap_snap[NTAP+3:4];
  assign w_multi = |(r_edge & (r_edge - 1'b1));
  assign w_sel = Address[7:3] == CH;
  assign w_off = Address[2:0];
  assign w_widx = 2'(w_off - 3'd1);
  assign w_rd = Read & w_sel;
  assign w_wr = Write & w_sel & ~Read;
  assign w_clr = w_wr & (w_off == 3'd0) & DataIn[9];
  assign w_empty = r_cnt == 7'd0;
  assign w_full = r_cnt == 7'(FIFO_DEPTH);
  assign w_pop = w_rd & (w_off == 3'd5) & ~w_empty;
  assign w_push = |r_edge & r_cfg[8] & (~w_full | w_pop);
  assign w_rec = {w_multi, 4'(w_cls), w_fine, 21'(r_stamp)};
  assign w_wx = 64'(r_win[w_widx]);
  assign w_unused = ^{tap_snap[0], w_wx[63:32]};
  assign class_hit = r_class_hit;
  assign hit_rdy = ~w_empty;
  assign DataOut = r_dout;
  // Leading-edge encode and per-class window match on the stage-1 edge vector
  always_comb begin
    w_fine = '0;
    w_cls = '0;
    for (int k = NTAP - 1; k >= 0; k--) if (r_edge[k]) w_fine = 6'(k);
    for (int j = 0; j < NCLASS; j++) w_cls[j] = r_cfg[j] & |(r_edge & r_win[j]);
  end
  // Register read mux; window slots beyond NCLASS read as zero
  always_comb begin
    w_rdata = '0;
    case (w_off)
      3'd0: w_rdata = 32'(r_cfg);
      3'd1, 3'd2, 3'd3, 3'd4: w_rdata = (int'(w_widx) < NCLASS) ? w_wx[31:0] : 32'h0;
      3'd5: w_rdata = w_empty ? 32'h0 : r_mem[r_rp];
      3'd6: w_rdata = {r_ovf, 24'h0, r_cnt};
      default: w_rdata = w_hitcnt;
    endcase
  end
  // Free-running coarse counter and stage-1 edge/stamp capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_coarse <= '0;
      r_edge <= '0;
      r_stamp <= '0;
    end else begin
      r_coarse <= r_coarse + 1'b1;
      r_edge <= w_edge;
      r_stamp <= r_coarse;
    end
  // Bus-writable config and windows; a concurrent Read suppresses the write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cfg <= '0;
      r_win[0] <= '1;
      r_win[1] <= WIN1_D[NTAP-1:0];
      r_win[2] <= WIN2_D[NTAP-1:0];
      r_win[3] <= '0;
    end else if (w_wr) begin
      if (w_off == 3'd0) r_cfg <= DataIn[8:0] & CFG_M;
      if (w_off inside {[3'd1:3'd4]} && int'(w_widx) < NCLASS) r_win[w_widx] <= NTAP'(DataIn);
    end
  // FIFO pointers, occupancy and sticky overflow; a full push is only accepted alongside a pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_clr) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + 7'(w_push) - 7'(w_pop);
      r_ovf <= (w_wr && w_off == 3'd6) ? 1'b0 : r_ovf | (|r_edge & r_cfg[8] & w_full & ~w_pop);
    end
  // Record storage, written on accepted pushes
  always_ff @(posedge clk)
    if (w_push & ~w_clr) r_mem[r_wp] <= w_rec;
  // Stage-2 trigger pulse and registered bus read data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_class_hit <= '0;
      r_dout <= '0;
    end else begin
      r_class_hit <= w_cls;
      r_dout <= w_rd ? w_rdata : 32'h0;
    end
`ifdef TDC_HITCNT_EN
  logic [7:0] r_hc [4];
  // Per-class saturating hit counters, cleared by reset or CFG[9]
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int j = 0; j < 4; j++) r_hc[j] <= '0;
    end else if (w_clr) begin
      for (int j = 0; j < 4; j++) r_hc[j] <= '0;
    end else begin
      for (int j = 0; j < NCLASS; j++) if (w_cls[j] && r_hc[j] != 8'hFF) r_hc[j] <= r_hc[j] + 8'd1;
    end
  assign w_hitcnt = {r_hc[3], r_hc[2], r_hc[1], r_hc[0]};
`else
  assign w_hitcnt = 32'h0;
`endif
endmodule

// File: tb/tb_tdc_hit_classifier.sv
// tb_tdc_hit_classifier: table-driven self-checking bench for tdc_hit_classifier
module tb_tdc_hit_classifier;
  typedef struct {
    logic [35:0] tap;
    logic        vld;
    logic [9:0]  cfg;
    logic [31:0] win1;
    logic [2:0]  cls;
    logic        push;
    logic [5:0]  fine;
    logic        multi;
  } vec_t;
  logic clk = 0, rst = 1;
  logic [35:0] tap_snap = '0;
  logic snap_vld = 0;
  logic [2:0] class_hit;
  logic hit_rdy;
  logic [31:0] DataOut, DataIn = '0, d;
  logic [7:0] Address = '0;
  logic Read = 0, Write = 0;
  logic [15:0] cnt, stamp, s0;
  int n_vec = 0, n_bad = 0;
  vec_t tbl[14];
  tdc_hit_classifier dut (
    .clk(clk), .rst(rst), .tap_snap(tap_snap), .snap_vld(snap_vld), .class_hit(class_hit),
    .hit_rdy(hit_rdy), .DataOut(DataOut), .DataIn(DataIn), .Address(Address), .Read(Read), .Write(Write)
  );
  always #10 clk = ~clk;
  always @(posedge clk or posedge rst) if (rst) cnt <= '0; else cnt <= cnt + 16'd1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] off, input logic [31:0] v);
    Address = {5'd0, off};
    DataIn = v;
    Write = 1;
    tick;
    Write = 0;
  endtask
  task automatic rd(input logic [2:0] off, output logic [31:0] v);
    Address = {5'd0, off};
    Read = 1;
    tick;
    Read = 0;
    v = DataOut;
  endtask
  function automatic logic [31:0] rec(input logic m, input logic [2:0] c, input logic [5:0] f, input logic [15:0] s);
    return {m, 1'b0, c, f, 5'b0, s};
  endfunction
  initial begin
    tbl[0]  = '{36'h0_000E_0000, 1'b1, 10'h107, 32'h0000F000, 3'b001, 1'b1, 6'd16, 1'b0};
    tbl[1]  = '{36'h0_0000_1C00, 1'b1, 10'h103, 32'h0000F000, 3'b001, 1'b1, 6'd9,  1'b0};
    tbl[2]  = '{36'h0_0000_1C00, 1'b1, 10'h103, 32'h00000200, 3'b011, 1'b1, 6'd9,  1'b0};
    tbl[3]  = '{36'h0_00E0_00E0, 1'b1, 10'h107, 32'h0000F000, 3'b001, 1'b1, 6'd4,  1'b1};
    tbl[4]  = '{36'h0_0001_C000, 1'b1, 10'h107, 32'h0000F000, 3'b011, 1'b1, 6'd13, 1'b0};
    tbl[5]  = '{36'h0_1C00_0000, 1'b1, 10'h107, 32'h0000F000, 3'b101, 1'b1, 6'd25, 1'b0};
    tbl[6]  = '{36'h0_1C00_0000, 1'b1, 10'h106, 32'h0000F000, 3'b100, 1'b1, 6'd25, 1'b0};
    tbl[7]  = '{36'h0_000E_0000, 1'b1, 10'h007, 32'h0000F000, 3'b001, 1'b0, 6'd16, 1'b0};
    tbl[8]  = '{36'h0_000E_0000, 1'b0, 10'h107, 32'h0000F000, 3'b000, 1'b0, 6'd0,  1'b0};
    tbl[9]  = '{36'h0_0000_000E, 1'b1, 10'h107, 32'h0000F000, 3'b001, 1'b1, 6'd0,  1'b0};
    tbl[10] = '{36'h7_0000_0000, 1'b1, 10'h107, 32'h0000F000, 3'b001, 1'b1, 6'd31, 1'b0};
    tbl[11] = '{36'hF_FFFF_FFFF, 1'b1, 10'h107, 32'h0000F000, 3'b000, 1'b0, 6'd0,  1'b0};
    tbl[12] = '{36'h0_0000_0006, 1'b1, 10'h107, 32'h0000F000, 3'b000, 1'b0, 6'd0,  1'b0};
    tbl[13] = '{36'h0_1C01_C000, 1'b1, 10'h107, 32'h0000F000, 3'b111, 1'b1, 6'd13, 1'b1};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset class_hit", 32'(class_hit), 32'h0);
    chk("reset hit_rdy", 32'(hit_rdy), 32'h0);
    chk("reset DataOut", DataOut, 32'h0);
    rd(0, d); chk("reset CFG", d, 32'h0);
    rd(1, d); chk("reset WIN0", d, 32'hFFFFFFFF);
    rd(2, d); chk("reset WIN1", d, 32'h0000F000);
    rd(3, d); chk("reset WIN2", d, 32'h0F000000);
    rd(4, d); chk("reset WIN3", d, 32'h0);
    rd(6, d); chk("reset STATUS", d, 32'h0);
    rd(5, d); chk("empty pop", d, 32'h0);
    Address = 8'h09; Read = 1; tick; Read = 0;
    chk("other channel read", DataOut, 32'h0);
    for (int i = 0; i < 14; i++) begin
      wr(0, 32'(tbl[i].cfg));
      wr(2, tbl[i].win1);
      tap_snap = tbl[i].tap;
      snap_vld = tbl[i].vld;
      stamp = cnt;
      tick;
      snap_vld = 0;
      tap_snap = '0;
      chk($sformatf("v%0d class_hit at +1", i), 32'(class_hit), 32'h0);
      tick;
      chk($sformatf("v%0d class_hit at +2", i), 32'(class_hit), 32'(tbl[i].cls));
      chk($sformatf("v%0d hit_rdy", i), 32'(hit_rdy), 32'(tbl[i].push));
      if (tbl[i].push) begin
        rd(5, d);
        chk($sformatf("v%0d fifo head", i), d, rec(tbl[i].multi, tbl[i].cls, tbl[i].fine, stamp));
      end
    end
    Address = 8'h02; DataIn = 32'h1234; Read = 1; Write = 1; tick; Read = 0; Write = 0;
    chk("read+write served read", DataOut, 32'h0000F000);
    rd(2, d); chk("read+write ignored write", d, 32'h0000F000);
    wr(4, 32'hFFFFFFFF);
    rd(4, d); chk("WIN3 ignores write", d, 32'h0);
    wr(0, 32'h107);
    s0 = cnt;
    tap_snap = 36'h0_000E_0000;
    snap_vld = 1;
    repeat (17) tick;
    snap_vld = 0;
    tap_snap = '0;
    tick; tick;
    rd(6, d); chk("overflow STATUS", d, 32'h80000010);
    for (int i = 0; i < 16; i++) begin
      rd(5, d);
      chk($sformatf("drain pop %0d", i), d, rec(1'b0, 3'b001, 6'd16, s0 + 16'(i)));
    end
    rd(5, d); chk("17th pop", d, 32'h0);
    rd(6, d); chk("sticky overflow", d, 32'h80000000);
    wr(6, 32'h0);
    rd(6, d); chk("STATUS write clears", d, 32'h0);
    s0 = cnt;
    tap_snap = 36'h0_000E_0000;
    snap_vld = 1;
    repeat (16) tick;
    snap_vld = 0;
    tick; tick;
    rd(6, d); chk("full STATUS", d, 32'h00000010);
    stamp = cnt;
    snap_vld = 1;
    tick;
    snap_vld = 0;
    tap_snap = '0;
    Address = 8'h05; Read = 1;
    tick;
    Read = 0;
    chk("push+pop when full head", DataOut, rec(1'b0, 3'b001, 6'd16, s0));
    rd(6, d); chk("push+pop occupancy", d, 32'h00000010);
    rd(5, d); chk("push+pop next head", d, rec(1'b0, 3'b001, 6'd16, s0 + 16'd1));
    wr(0, 32'h300);
    rd(6, d); chk("CFG[9] clears FIFO", d, 32'h0);
    rd(0, d); chk("CFG[9] self-clears", d, 32'h100);
    wr(0, 32'h107);
    begin
      int guard = 0;
      while (cnt != 16'hFFFF && guard < 70000) begin
        tick;
        guard++;
      end
      chk("coarse reaches FFFF", 32'(cnt), 32'h0000FFFF);
    end
    tap_snap = 36'h0_000E_0000;
    snap_vld = 1;
    tick; tick;
    snap_vld = 0;
    tap_snap = '0;
    tick; tick;
    rd(5, d); chk("stamp FFFF", d, rec(1'b0, 3'b001, 6'd16, 16'hFFFF));
    rd(5, d); chk("stamp wraps to 0", d, rec(1'b0, 3'b001, 6'd16, 16'h0000));
    tap_snap = 36'h0_000E_0000;
    snap_vld = 1;
    tick;
    snap_vld = 0;
    tap_snap = '0;
    #2 rst = 1;
    #2 rst = 0;
    tick;
    chk("rst in pipe class_hit", 32'(class_hit), 32'h0);
    chk("rst in pipe hit_rdy", 32'(hit_rdy), 32'h0);
    tick;
    chk("rst in pipe class_hit later", 32'(class_hit), 32'h0);
    rd(5, d); chk("rst in pipe FIFO empty", d, 32'h0);
    rd(0, d); chk("rst in pipe CFG", d, 32'h0);
    wr(0, 32'h007);
    tap_snap = 36'h0_000E_0000;
    snap_vld = 1;
`ifdef TDC_HITCNT_EN
    repeat (300) tick;
    snap_vld = 0;
    tap_snap = '0;
    tick; tick;
    rd(7, d); chk("HITCNT saturates", d, 32'h000000FF);
    wr(0, 32'h200);
    rd(7, d); chk("HITCNT cleared", d, 32'h0);
`else
    repeat (5) tick;
    snap_vld = 0;
    tap_snap = '0;
    tick; tick;
    rd(7, d); chk("HITCNT absent", d, 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
